// File: rtl/servo_pwm_capture_if.sv
// Signal bundle between a servo PWM source/consumer and the capture block.
interface servo_pwm_capture_if;
   logic        tick;
   logic        PWMIn;
   logic [7:0]  duty;
   logic [11:0] period;
   logic        valid;
   logic        range_err;
   logic        signal_lost;

   modport master (
      output tick,
      output PWMIn,
      input  duty,
      input  period,
      input  valid,
      input  range_err,
      input  signal_lost
   );

   modport slave (
      input  tick,
      input  PWMIn,
      output duty,
      output period,
      output valid,
      output range_err,
      output signal_lost
   );
endinterface

// File: rtl/servo_pwm_capture.sv
// Measures a servo PWM pulse train on a 128 kHz tick and recovers the 8-bit duty code,
// the frame period, a range-error flag and a loss-of-signal flag.
module servo_pwm_capture #(
   parameter int unsigned CLOCK_TICKS_MIN = 64,
   parameter int unsigned TIMEOUT         = 3072  // must fit the 12-bit timeout counter
) (
   input logic                clock,
   input logic                reset,
   servo_pwm_capture_if.slave bus
);
   typedef enum logic [1:0] {StArm, StWaitRise, StHigh, StLow} state_e;

   localparam logic [11:0] WidthMin = 12'(CLOCK_TICKS_MIN);
   localparam logic [11:0] WidthMax = 12'(CLOCK_TICKS_MIN + 255);
   localparam logic [11:0] Timeout  = 12'(TIMEOUT);

   state_e      state_q, state_d;
   logic        sync1_q, sync2_q, prev_q;
   logic [11:0] width_q, width_d;
   logic [11:0] per_cnt_q, per_cnt_d;
   logic [11:0] to_cnt_q, to_cnt_d;
   logic [7:0]  duty_q, duty_d;
   logic [11:0] period_q, period_d;
   logic        valid_q, valid_d;
   logic        range_err_q, range_err_d;
   logic        lost_q, lost_d;

   logic        rise, fall, timeout;
   logic [11:0] to_next, width_off;

   function automatic logic [11:0] sat_inc(input logic [11:0] x);
      return (x == 12'hfff) ? x : x + 12'd1;
   endfunction

   assign rise      = bus.tick & ~prev_q & sync2_q;
   assign fall      = bus.tick & prev_q & ~sync2_q;
   assign to_next   = to_cnt_q + 12'd1;
   // A rise on the timeout tick restarts the counter instead of declaring loss.
   assign timeout   = bus.tick & ~rise & (to_next == Timeout);
   assign width_off = width_q - WidthMin;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= bus.PWMIn;
         sync2_q <= sync1_q;
         if (bus.tick) prev_q <= sync2_q;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= StArm;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (timeout) begin
         state_d = StArm;
      end else if (bus.tick) begin
         case (state_q)
            StArm:      if (!sync2_q) state_d = StWaitRise;
            StWaitRise: if (rise)     state_d = StHigh;
            StHigh:     if (fall)     state_d = StLow;
            StLow:      if (rise)     state_d = StHigh;
            default:                  state_d = StArm;
         endcase
      end
   end

   always_comb begin
      width_d     = width_q;
      per_cnt_d   = per_cnt_q;
      to_cnt_d    = to_cnt_q;
      duty_d      = duty_q;
      period_d    = period_q;
      range_err_d = range_err_q;
      lost_d      = lost_q;
      valid_d     = 1'b0;
      if (bus.tick) begin
         to_cnt_d = (rise || timeout) ? 12'd0 : to_next;
         if (timeout) begin
            lost_d = 1'b1;
         end else begin
            case (state_q)
               StWaitRise: begin
                  if (rise) begin
                     width_d   = 12'd1;
                     per_cnt_d = 12'd1;
                  end
               end
               StHigh: begin
                  per_cnt_d = sat_inc(per_cnt_q);
                  if (fall) begin
                     valid_d = 1'b1;
                     lost_d  = 1'b0;
                     if (width_q < WidthMin) begin
                        duty_d      = 8'd0;
                        range_err_d = 1'b1;
                     end else if (width_q > WidthMax) begin
                        duty_d      = 8'd255;
                        range_err_d = 1'b1;
                     end else begin
                        duty_d      = width_off[7:0];
                        range_err_d = 1'b0;
                     end
                  end else begin
                     width_d = sat_inc(width_q);
                  end
               end
               StLow: begin
                  if (rise) begin
                     period_d  = per_cnt_q;
                     width_d   = 12'd1;
                     per_cnt_d = 12'd1;
                  end else begin
                     per_cnt_d = sat_inc(per_cnt_q);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         width_q     <= 12'd0;
         per_cnt_q   <= 12'd0;
         to_cnt_q    <= 12'd0;
         duty_q      <= 8'd0;
         period_q    <= 12'd0;
         valid_q     <= 1'b0;
         range_err_q <= 1'b0;
         lost_q      <= 1'b1;
      end else begin
         width_q     <= width_d;
         per_cnt_q   <= per_cnt_d;
         to_cnt_q    <= to_cnt_d;
         duty_q      <= duty_d;
         period_q    <= period_d;
         valid_q     <= valid_d;
         range_err_q <= range_err_d;
         lost_q      <= lost_d;
      end
   end

   assign bus.duty        = duty_q;
   assign bus.period      = period_q;
   assign bus.valid       = valid_q;
   assign bus.range_err   = range_err_q;
   assign bus.signal_lost = lost_q;
endmodule

// File: tb/tb_servo_pwm_capture.sv
// Scoreboard bench for servo_pwm_capture: pulses are driven on a tick every third clock.
module tb_servo_pwm_capture;
   logic clock;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   typedef struct packed {
      logic [7:0] duty;
      logic       range_err;
   } exp_t;

   exp_t sb[$];

   servo_pwm_capture_if bus ();

   servo_pwm_capture dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      bus.tick = 1'b0;
      forever begin
         @(negedge clock);
         cyc      = cyc + 1;
         bus.tick = (cyc % 3 == 0);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Returns at the falling edge following the n-th tick edge.
   task automatic wait_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         do @(posedge clock); while (bus.tick !== 1'b1);
      end
      @(negedge clock);
   endtask

   task automatic pulse(input int hi, input int lo, input logic [7:0] d, input logic re);
      exp_t e;
      bus.PWMIn = 1'b1;
      wait_ticks(hi);
      bus.PWMIn = 1'b0;
      e.duty      = d;
      e.range_err = re;
      sb.push_back(e);
      wait_ticks(lo);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_duty"}, 32'(bus.duty), 0);
      check({tag, "_period"}, 32'(bus.period), 0);
      check({tag, "_valid"}, 32'(bus.valid), 0);
      check({tag, "_range_err"}, 32'(bus.range_err), 0);
      check({tag, "_signal_lost"}, 32'(bus.signal_lost), 1);
   endtask

   always @(negedge clock) begin
      if (bus.valid === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_valid", 32'(bus.duty), 32'hffff_ffff);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("sb_duty", 32'(bus.duty), 32'(e.duty));
            check("sb_range_err", 32'(bus.range_err), 32'(e.range_err));
            check("sb_signal_lost", 32'(bus.signal_lost), 0);
         end
      end
   end

   initial begin
      reset     = 1'b1;
      bus.PWMIn = 1'b1;
      repeat (4) @(negedge clock);
      check_reset_values("rst");
      reset = 1'b0;
      // Pulse already high at reset release is never measured.
      wait_ticks(100);
      bus.PWMIn = 1'b0;
      wait_ticks(50);
      check("high_at_reset_lost", 32'(bus.signal_lost), 1);

      pulse(64, 2497, 8'd0, 1'b0);
      check("first_rise_period", 32'(bus.period), 0);
      pulse(64, 2497, 8'd0, 1'b0);
      check("frame_period", 32'(bus.period), 2561);

      pulse(264, 200, 8'd200, 1'b0);
      pulse(319, 200, 8'd255, 1'b0);
      check("period_319", 32'(bus.period), 464);
      pulse(40, 200, 8'd0, 1'b1);
      pulse(400, 200, 8'd255, 1'b1);
      check("period_400", 32'(bus.period), 240);
      pulse(63, 200, 8'd0, 1'b1);
      pulse(320, 200, 8'd255, 1'b1);
      pulse(65, 200, 8'd1, 1'b0);

      // Loss of signal: rise of the 80-tick pulse restarts the timeout count.
      pulse(80, 2980, 8'd16, 1'b0);
      check("pre_timeout_lost", 32'(bus.signal_lost), 0);
      wait_ticks(20);
      check("timeout_lost", 32'(bus.signal_lost), 1);
      check("timeout_duty_hold", 32'(bus.duty), 16);
      check("timeout_period_hold", 32'(bus.period), 265);
      pulse(100, 200, 8'd36, 1'b0);
      check("after_loss_period", 32'(bus.period), 265);

      // Reset in the middle of a 264-tick pulse.
      bus.PWMIn = 1'b1;
      wait_ticks(50);
      reset = 1'b1;
      #1;
      check_reset_values("mid_rst");
      repeat (3) @(negedge clock);
      reset = 1'b0;
      wait_ticks(214);
      bus.PWMIn = 1'b0;
      wait_ticks(100);
      check("aborted_pulse_lost", 32'(bus.signal_lost), 1);
      pulse(150, 200, 8'd86, 1'b0);
      check("after_rst_lost", 32'(bus.signal_lost), 0);

      check("sb_drain", 32'(sb.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
